// File: rtl/fib_sequencer.sv
// Purpose: round-robin arbiter and sequencer for a shared iterative Fibonacci datapath (A/B add-and-shift).
// Latency: o_Valid arrives n+2 cycles after the cycle a request is sampled; one request occupies n+3 cycles.
// Backpressure: level requests are held until their result; a losing request waits indefinitely, no timeout.

// Shared A/B datapath: each step computes A <= B, B <= A+B and tracks overflow of the true values.
module fib_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a_dat,
  output logic [WIDTH-1:0] b_dat,
  output logic             a_ovf,
  output logic             b_ovf
);

  // One extra bit captures the carry-out of the truncated add.
  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_dat} + {1'b0, b_dat};

  // Load seeds F(0)/F(1); step advances one term. The overflow flags are sticky
  // because the true sequence is monotonic: once a term exceeds 2^WIDTH, all later ones do.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || load) begin
      a_dat <= '0;
      b_dat <= WIDTH'(1);
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
    end else if (step) begin
      a_dat <= b_dat;
      b_dat <= sum[WIDTH-1:0];
      a_ovf <= b_ovf;
      b_ovf <= a_ovf | b_ovf | sum[WIDTH];
    end
  end

endmodule

module fib_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Req0,
  input  logic [4:0]       i_Index0,
  input  logic             i_Req1,
  input  logic [4:0]       i_Index1,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic             o_Owner,
  output logic [WIDTH-1:0] o_Value,
  output logic             o_Overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Round-robin pointer: names the requester that wins when both are asking.
  logic            rr_ptr;
  logic [4:0]      count;

  // Control decoded from the FSM for the current cycle.
  logic            grant;
  logic            winner;
  logic            step;
  logic            capture;

  logic [WIDTH-1:0] a_dat;
  logic [WIDTH-1:0] b_dat;
  logic             a_ovf;
  logic             b_ovf;

  fib_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .load    (grant),
    .step    (step),
    .a_dat   (a_dat),
    .b_dat   (b_dat),
    .a_ovf   (a_ovf),
    .b_ovf   (b_ovf)
  );

  // Next-state, arbitration and status decode; all outputs defaulted first.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    o_Busy    = 1'b0;
    o_Valid   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_Req0 || i_Req1) begin
          grant     = 1'b1;
          // A lone request wins outright; a tie goes to the pointer's requester.
          winner    = (i_Req0 && i_Req1) ? rr_ptr : i_Req1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_Busy = 1'b1;
        if (count != 5'd0) begin
          step = 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_Busy    = 1'b1;
        o_Valid   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight request.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping: pointer moves to the loser, owner and index are latched at grant.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rr_ptr  <= 1'b0;
      o_Owner <= 1'b0;
      count   <= 5'd0;
    end else if (grant) begin
      rr_ptr  <= ~winner;
      o_Owner <= winner;
      count   <= winner ? i_Index1 : i_Index0;
    end else if (step) begin
      count   <= count - 5'd1;
    end
  end

  // Result registers update on the edge entering DONE and hold until the next result.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Value    <= '0;
      o_Overflow <= 1'b0;
    end else if (capture) begin
      o_Value    <= a_dat;
      o_Overflow <= a_ovf;
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer: latency, values, overflow, round-robin and reset recovery.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed Fibonacci terms modulo 256.
module tb_fib_sequencer;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_Req0;
  logic [4:0] i_Index0;
  logic       i_Req1;
  logic [4:0] i_Index1;
  logic       o_Busy;
  logic       o_Valid;
  logic       o_Owner;
  logic [7:0] o_Value;
  logic       o_Overflow;

  int checks   = 0;
  int failures = 0;

  fib_sequencer #(
    .WIDTH (8)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Req0     (i_Req0),
    .i_Index0   (i_Index0),
    .i_Req1     (i_Req1),
    .i_Index1   (i_Index1),
    .o_Busy     (o_Busy),
    .o_Valid    (o_Valid),
    .o_Owner    (o_Owner),
    .o_Value    (o_Value),
    .o_Overflow (o_Overflow)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask

  // Advance until o_Valid, counting cycles from the current (request) cycle.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_Valid && lat < 80);
    chk({tag, "_valid_seen"}, o_Valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  o_Busy, 0);
    chk({tag, "_valid"}, o_Valid, 0);
    chk({tag, "_owner"}, o_Owner, 0);
    chk({tag, "_value"}, o_Value, 0);
    chk({tag, "_ovf"},   o_Overflow, 0);
  endtask

  int lat;
  int vcnt;
  int cyc;
  int vtime  [4];
  int vowner [4];
  int vvalue [4];
  int idx_tab [5] = '{0, 1, 13, 14, 31};
  int val_tab [5] = '{0, 1, 233, 121, 221};
  int ovf_tab [5] = '{0, 0, 0, 1, 1};
  bit saw_valid;

  initial begin
    i_Reset  = 1'b1;
    i_Req0   = 1'b0;
    i_Req1   = 1'b0;
    i_Index0 = 5'd0;
    i_Index1 = 5'd0;
    tick();
    tick();
    i_Reset = 1'b0;
    check_reset_outputs("rst");

    // Single request on requester 0, n=10.
    i_Req0   = 1'b1;
    i_Index0 = 5'd10;
    wait_valid("r0n10", lat);
    chk("r0n10_lat",   lat, 12);
    chk("r0n10_owner", o_Owner, 0);
    chk("r0n10_value", o_Value, 55);
    chk("r0n10_ovf",   o_Overflow, 0);
    i_Req0 = 1'b0;
    tick();
    chk("r0n10_pulse", o_Valid, 0);
    chk("r0n10_idle",  o_Busy, 0);
    chk("r0n10_hold",  o_Value, 55);

    // Boundary indices on requester 1.
    for (int k = 0; k < 5; k++) begin
      i_Req1   = 1'b1;
      i_Index1 = 5'(idx_tab[k]);
      wait_valid($sformatf("r1n%0d", idx_tab[k]), lat);
      chk($sformatf("r1n%0d_lat", idx_tab[k]),   lat, idx_tab[k] + 2);
      chk($sformatf("r1n%0d_owner", idx_tab[k]), o_Owner, 1);
      chk($sformatf("r1n%0d_value", idx_tab[k]), o_Value, val_tab[k]);
      chk($sformatf("r1n%0d_ovf", idx_tab[k]),   o_Overflow, ovf_tab[k]);
      i_Req1 = 1'b0;
      tick();
      chk($sformatf("r1n%0d_pulse", idx_tab[k]), o_Valid, 0);
    end

    // Both requests held from reset: grants alternate 0,1,0,1.
    i_Reset = 1'b1;
    tick();
    i_Reset  = 1'b0;
    i_Req0   = 1'b1;
    i_Index0 = 5'd5;
    i_Req1   = 1'b1;
    i_Index1 = 5'd3;
    vcnt = 0;
    cyc  = 0;
    while (vcnt < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (o_Valid) begin
        vtime[vcnt]  = cyc;
        vowner[vcnt] = int'(o_Owner);
        vvalue[vcnt] = int'(o_Value);
        vcnt++;
      end
    end
    i_Req0 = 1'b0;
    i_Req1 = 1'b0;
    chk("rr_count", vcnt, 4);
    chk("rr_first_lat", vtime[0], 7);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_owner", k), vowner[k], k % 2);
      chk($sformatf("rr%0d_value", k), vvalue[k], (k % 2 == 0) ? 5 : 2);
    end
    chk("rr_gap01", vtime[1] - vtime[0], 6);
    chk("rr_gap12", vtime[2] - vtime[1], 8);
    chk("rr_gap23", vtime[3] - vtime[2], 6);
    tick();
    chk("rr_idle", o_Busy, 0);

    // Requester 1 arrives mid-service; index change after grant is ignored.
    i_Req0   = 1'b1;
    i_Index0 = 5'd20;
    tick();
    tick();
    i_Req1   = 1'b1;
    i_Index1 = 5'd3;
    i_Index0 = 5'd2;
    wait_valid("late", lat);
    chk("late_lat",   lat + 2, 22);
    chk("late_owner", o_Owner, 0);
    chk("late_value", o_Value, 109);
    chk("late_ovf",   o_Overflow, 1);
    i_Req0 = 1'b0;
    tick();
    chk("late_idle", o_Busy, 0);
    wait_valid("waiter", lat);
    chk("waiter_lat",   lat, 5);
    chk("waiter_owner", o_Owner, 1);
    chk("waiter_value", o_Value, 2);
    i_Req1 = 1'b0;
    tick();

    // Reset mid-RUN with the pointer favouring requester 1 beforehand.
    i_Req0   = 1'b1;
    i_Index0 = 5'd10;
    tick();
    i_Req1   = 1'b1;
    i_Index1 = 5'd7;
    saw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_Valid) saw_valid = 1'b1;
    end
    chk("mid_busy", o_Busy, 1);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    if (o_Valid) saw_valid = 1'b1;
    chk("mid_no_valid", saw_valid, 0);
    check_reset_outputs("mid_rst");
    wait_valid("regrant", lat);
    chk("regrant_lat",   lat, 12);
    chk("regrant_owner", o_Owner, 0);
    chk("regrant_value", o_Value, 55);
    i_Req0 = 1'b0;
    tick();
    wait_valid("after", lat);
    chk("after_lat",   lat, 9);
    chk("after_owner", o_Owner, 1);
    chk("after_value", o_Value, 13);
    chk("after_ovf",   o_Overflow, 0);
    i_Req1 = 1'b0;
    tick();
    chk("final_idle", o_Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
